// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline latch: a chain of STAGES registered stages, each with a
// main slot and a skid slot. Holds up to 2*STAGES payloads in FIFO order.
// The skid slot lets each stage accept one more payload after its downstream
// stalls. Because of that, ready is taken straight from a register and never
// passes combinationally through the chain.

module pipe_latch_elastic #(
    parameter int                 DATA_W    = 64,
    parameter int                 STAGES    = 1,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data,
    input  logic                               flush,
    output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    logic [STAGES-1:0] m_v;
    logic [STAGES-1:0] s_v;
    logic [DATA_W-1:0] m_d [STAGES];
    logic [DATA_W-1:0] s_d [STAGES];

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] dn_ready;
    logic [STAGES-1:0] up_fire;
    logic [STAGES-1:0] dn_fire;
    logic [DATA_W-1:0] up_data [STAGES];

    logic in_fire;
    logic out_fire;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              mv;
        logic              sv;
        logic [DATA_W-1:0] md;
        logic [DATA_W-1:0] sd;

        // Stage k is fed by the block input or by stage k-1. A flush gates the
        // block input so that nothing enters during a squash.
        if (k == 0) begin : g_first
            assign up_valid[k] = in_valid & ~flush;
            assign up_data[k]  = in_data;
        end else begin : g_chain
            assign up_valid[k] = m_v[k-1];
            assign up_data[k]  = m_d[k-1];
        end

        // Stage k drains into stage k+1 or into the block output. Nothing
        // leaves the block during a flush.
        if (k == STAGES-1) begin : g_last
            assign dn_ready[k] = out_ready & ~flush;
        end else begin : g_mid
            assign dn_ready[k] = ~s_v[k+1];
        end

        assign up_fire[k] = up_valid[k] & ~s_v[k];
        assign dn_fire[k] = m_v[k] & dn_ready[k];

        assign m_v[k] = mv;
        assign s_v[k] = sv;
        assign m_d[k] = md;
        assign s_d[k] = sd;

        // Main/skid update. The skid always refills main before any newer
        // entry, which keeps the FIFO order. up_fire cannot occur while the
        // skid is full, so the skid is never overwritten.
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                mv <= 1'b0;
                sv <= 1'b0;
                md <= FLUSH_VAL;
                sd <= FLUSH_VAL;
            end else if (flush) begin
                mv <= 1'b0;
                sv <= 1'b0;
                md <= FLUSH_VAL;
                sd <= FLUSH_VAL;
            end else if (!mv || dn_fire[k]) begin
                if (sv) begin
                    mv <= 1'b1;
                    md <= sd;
                    sv <= 1'b0;
                end else begin
                    mv <= up_fire[k];
                    if (up_fire[k]) begin
                        md <= up_data[k];
                    end
                end
            end else if (up_fire[k]) begin
                sd <= up_data[k];
                sv <= 1'b1;
            end
        end
    end

    assign in_ready  = ~s_v[0] & ~flush;
    assign out_valid = m_v[STAGES-1] & ~flush;
    assign out_data  = m_d[STAGES-1];

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy is tracked as a running count of block-level transfers. This
    // avoids a popcount over every slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule
